// File: rtl/tpumac_seq.sv
// Sequencer for a DIM x DIM tpumac systolic array.
// Runs an optional accumulator preload (CLEAR), then a skewed compute sweep, then a one-cycle DONE.
module tpumac_seq #(
  parameter int DIM   = 8,
  parameter int CNT_W = 5,
  parameter int ROW_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clr_c,
  input  logic             stall,
  input  logic             abort,
  output logic             en,
  output logic             WrEn,
  output logic [ROW_W-1:0] c_row,
  output logic [CNT_W-1:0] k_idx,
  output logic [DIM-1:0]   feed_en,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLEAR   = 2'd1,
    COMPUTE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(DIM - 1);
  localparam logic [CNT_W-1:0] K_LAST   = CNT_W'(3 * DIM - 3);

  state_t           state_q, state_d;
  logic [ROW_W-1:0] c_row_q, c_row_d;
  logic [CNT_W-1:0] k_idx_q, k_idx_d;
  logic [CNT_W:0]   k_ext_s;

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c_row_q <= '0;
      k_idx_q <= '0;
    end else begin
      state_q <= state_d;
      c_row_q <= c_row_d;
      k_idx_q <= k_idx_d;
    end
  end

  // Next-state and counter logic; abort outranks stall and terminal counts.
  always_comb begin
    state_d = state_q;
    c_row_d = c_row_q;
    k_idx_d = k_idx_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          c_row_d = '0;
          k_idx_d = '0;
          state_d = clr_c ? CLEAR : COMPUTE;
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        if (abort) begin
          state_d = IDLE;
          c_row_d = '0;
          k_idx_d = '0;
        end else if (stall) begin
          state_d = CLEAR;
        end else if (c_row_q == ROW_LAST) begin
          state_d = COMPUTE;
          c_row_d = '0;
          k_idx_d = '0;
        end else begin
          c_row_d = c_row_q + ROW_W'(1'b1);
        end
      end
      COMPUTE: begin
        if (abort) begin
          state_d = IDLE;
          c_row_d = '0;
          k_idx_d = '0;
        end else if (stall) begin
          state_d = COMPUTE;
        end else if (k_idx_q == K_LAST) begin
          state_d = DONE;
          k_idx_d = '0;
        end else begin
          k_idx_d = k_idx_q + CNT_W'(1'b1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        c_row_d = '0;
        k_idx_d = '0;
      end
    endcase
  end

  // Array strobes follow stall combinationally; feeder r is live while operand (k_idx - r) is in 0..DIM-1.
  always_comb begin
    en      = (state_q == COMPUTE) && !stall;
    WrEn    = (state_q == CLEAR) && !stall;
    k_ext_s = {1'b0, k_idx_q};
    feed_en = '0;
    if (en) begin
      for (int r = 0; r < DIM; r++) begin
        feed_en[r] = (k_ext_s >= (CNT_W+1)'(r)) && (k_ext_s < (CNT_W+1)'(r + DIM));
      end
    end else begin
      feed_en = '0;
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign c_row = c_row_q;
  assign k_idx = k_idx_q;

endmodule

// File: tb/tb_tpumac_seq.sv
// Scoreboard bench for tpumac_seq at DIM=4: stimulus queues expected array events, a monitor checks them.
module tb_tpumac_seq;
  localparam int DIM   = 4;
  localparam int CNT_W = 4;
  localparam int ROW_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0, clr_c = 1'b0, stall = 1'b0, abort = 1'b0;
  logic             en, WrEn, busy, done;
  logic [ROW_W-1:0] c_row;
  logic [CNT_W-1:0] k_idx;
  logic [DIM-1:0]   feed_en;

  typedef struct {
    int             kind;  // 0 = preload row, 1 = compute step, 2 = done
    int             idx;
    logic [DIM-1:0] feed;
  } ev_t;

  ev_t q[$];
  bit  exp_busy = 1'b0;
  bit  exp_act  = 1'b0;
  int  n_vec = 0;
  int  n_err = 0;

  tpumac_seq #(.DIM(DIM), .CNT_W(CNT_W), .ROW_W(ROW_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clr_c(clr_c), .stall(stall), .abort(abort),
    .en(en), .WrEn(WrEn), .c_row(c_row), .k_idx(k_idx), .feed_en(feed_en),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // A pass is: DIM preload rows (optional), 3*DIM-2 compute steps, one done.
  task automatic push_pass(input bit clr);
    ev_t e;
    if (clr) begin
      for (int i = 0; i < DIM; i++) begin
        e.kind = 0; e.idx = i; e.feed = '0;
        q.push_back(e);
      end
    end
    for (int k = 0; k < 3 * DIM - 2; k++) begin
      e.kind = 1; e.idx = k; e.feed = '0;
      for (int r = 0; r < DIM; r++) begin
        if (k - r >= 0 && k - r < DIM) e.feed[r] = 1'b1;
      end
      q.push_back(e);
    end
    e.kind = 2; e.idx = 0; e.feed = '0;
    q.push_back(e);
  endtask

  // Monitor: compare whatever the DUT presents against the head of the scoreboard.
  always @(negedge clk) begin
    ev_t e;
    int  kind;
    bit  act;
    act = en | WrEn | done;
    chk("busy", int'(busy), int'(exp_busy));
    chk("activity", int'(act), int'(exp_act));
    if (en && WrEn) chk("en_wren_exclusive", 1, 0);
    if (!en && feed_en != '0) chk("feed_en_idle", int'(feed_en), 0);
    if (act) begin
      kind = WrEn ? 0 : (en ? 1 : 2);
      if (q.size() == 0) begin
        chk("unexpected_output", kind, -1);
      end else begin
        e = q.pop_front();
        chk("event_kind", kind, e.kind);
        if (e.kind == 0) chk("c_row", int'(c_row), e.idx);
        if (e.kind == 1) begin
          chk("k_idx", int'(k_idx), e.idx);
          chk("feed_en", int'(feed_en), int'(e.feed));
        end
      end
    end
  end

  // Runs one pass starting in an IDLE cycle at posedge+1; returns at posedge+1 of the next IDLE cycle.
  task automatic run_pass(input bit clr, input int stall_pct, input int abort_at,
                          input int hold_at, input int hold_len);
    int total, step, held;
    bit aborted;
    start = 1'b1; clr_c = clr; stall = 1'($urandom % 2); abort = 1'b0;
    exp_busy = 1'b0; exp_act = 1'b0;
    push_pass(clr);
    total = (clr ? DIM : 0) + 3 * DIM - 2;
    step = 0; held = 0; aborted = 1'b0;
    while (step < total) begin
      @(posedge clk); #1;
      start = 1'($urandom % 2); clr_c = 1'($urandom % 2);
      exp_busy = 1'b1; abort = 1'b0;
      if (step == abort_at) begin
        abort = 1'b1; stall = 1'b1; exp_act = 1'b0; aborted = 1'b1;
        break;
      end
      if (step == hold_at && held < hold_len) begin
        stall = 1'b1; held++;
      end else begin
        stall = ($urandom_range(99) < stall_pct) ? 1'b1 : 1'b0;
      end
      exp_act = !stall;
      if (!stall) step++;
    end
    @(posedge clk); #1;
    if (!aborted) begin
      start = 1'($urandom % 2); stall = 1'($urandom % 2); abort = 1'($urandom % 2);
      exp_busy = 1'b1; exp_act = 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0; abort = 1'b0; stall = 1'b0; clr_c = 1'b0;
    exp_busy = 1'b0; exp_act = 1'b0;
    if (aborted) q.delete();
    else chk("pass_drained", q.size(), 0);
  endtask

  initial begin
    int tot, ab;
    bit c;
    #12;
    chk("reset_busy", int'(busy), 0);
    chk("reset_en_wren", int'({en, WrEn, done}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_pass(1'b1, 0, -1, -1, 0);   // preload + compute, no stall
    run_pass(1'b0, 0, -1, -1, 0);   // compute only
    run_pass(1'b0, 0, -1, 5, 3);    // 3-cycle stall at k_idx=5
    run_pass(1'b0, 0, 2, -1, 0);    // abort at k_idx=2
    run_pass(1'b1, 0, -1, -1, 0);   // started right after the abort

    // start together with abort in IDLE stays idle
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(posedge clk); #1;

    // asynchronous reset in the middle of CLEAR
    start = 1'b1; clr_c = 1'b1;
    push_pass(1'b1);
    @(posedge clk); #1;
    start = 1'b0; clr_c = 1'b0; exp_busy = 1'b1; exp_act = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0; exp_busy = 1'b0; exp_act = 1'b0;
    q.delete();
    #1;
    chk("async_reset_strobes", int'({en, WrEn, busy, done}), 0);
    chk("async_reset_counts", int'({c_row, k_idx}), 0);
    chk("async_reset_feed", int'(feed_en), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_pass(1'b1, 0, -1, -1, 0);

    for (int p = 0; p < 40; p++) begin
      c   = 1'($urandom % 2);
      tot = (c ? DIM : 0) + 3 * DIM - 2;
      ab  = ($urandom % 5 == 0) ? int'($urandom_range(tot - 1)) : -1;
      run_pass(c, 30, ab, -1, 0);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/tpumac_seq.md
TPUMAC_SEQ -- requirements
Module: tpumac_seq

Interface
REQ-001 Parameter DIM, default 8, is the systolic array edge (DIM x DIM tpumac cells); legal range 2..16.
REQ-002 Parameter CNT_W, default 5, is the counter width; it SHALL hold 3*DIM-2.
REQ-003 Parameter ROW_W, default 3, is the row-select width; it SHALL hold DIM-1.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle request to run one matrix pass; sampled only in IDLE.
REQ-007 clr_c  input  1  sampled with start; 1 = preload accumulators via WrEn before compute.
REQ-008 stall  input  1  operand feeders not ready; freezes sequencing while high.
REQ-009 abort  input  1  synchronous cancel of the current pass.
REQ-010 en  output  1  array register enable, broadcast to every cell.
REQ-011 WrEn  output  1  array accumulator-load enable, broadcast to every cell.
REQ-012 c_row  output  ROW_W  row whose Cin is being loaded while WrEn=1.
REQ-013 k_idx  output  CNT_W  compute-cycle index, 0..3*DIM-3.
REQ-014 feed_en  output  DIM  bit r=1: feeder r presents operand (k_idx-r); bit r=0: feeder r presents zero.
REQ-015 busy  output  1  high in any state except IDLE.
REQ-016 done  output  1  one-cycle pulse on pass completion.

Function
REQ-017 FSM states SHALL be IDLE, CLEAR, COMPUTE, DONE.
REQ-018 IDLE, start=1, abort=0, clr_c=1 -> CLEAR next cycle; clr_c=0 -> COMPUTE next cycle.
REQ-019 start SHALL be ignored in any state other than IDLE.
REQ-020 CLEAR: WrEn=1 and en=0; c_row counts 0..DIM-1, one row per non-stalled cycle; after row DIM-1 -> COMPUTE.
REQ-021 COMPUTE: en=1, WrEn=0; k_idx counts 0..3*DIM-3, one step per non-stalled cycle; after k_idx=3*DIM-3 -> DONE.
REQ-022 Total COMPUTE length SHALL be exactly 3*DIM-2 enabled cycles: DIM operand steps, plus 2*(DIM-1) skew fill and drain.
REQ-023 feed_en[r] SHALL be 1 only in COMPUTE with r <= k_idx < r+DIM; otherwise 0.
REQ-024 stall=1 in CLEAR or COMPUTE: en=0, WrEn=0, feed_en=0 in that cycle; c_row, k_idx and state hold.
REQ-025 en, WrEn and feed_en SHALL depend combinationally on stall; all other outputs SHALL come from registered state only.
REQ-026 DONE: done=1, busy=1 for exactly one cycle, then -> IDLE.
REQ-027 abort=1 in CLEAR or COMPUTE -> IDLE next cycle; counters cleared; no done pulse.
REQ-028 abort has priority over stall and over counter terminal conditions.
REQ-029 abort together with start in IDLE -> remain in IDLE.
REQ-030 abort in DONE SHALL be ignored; done still pulses.
REQ-031 stall in IDLE or DONE SHALL have no effect.
REQ-032 en and WrEn SHALL never both be 1 in the same cycle.
REQ-033 Counters SHALL reset to 0 on entry to CLEAR and on entry to COMPUTE, and SHALL never wrap.

Reset
REQ-034 rst_n=0 SHALL immediately force state=IDLE, c_row=0, k_idx=0, en=0, WrEn=0, feed_en=0, busy=0, done=0, regardless of clk.
REQ-035 Reset asserted mid-pass SHALL abandon the pass without a done pulse; first start after release is accepted normally.

Verification
REQ-036 DIM=4: start with clr_c=1, no stall -> 4 cycles WrEn=1 (c_row 0,1,2,3), then 10 cycles en=1 (k_idx 0..9), then done for 1 cycle; busy high for 15 cycles.
REQ-037 DIM=4: start with clr_c=0 -> CLEAR skipped; en=1 for 10 cycles; feed_en=0001 at k_idx=0, 1111 at k_idx=3, 1000 at k_idx=6, 0000 at k_idx=7..9.
REQ-038 DIM=4: stall high for 3 cycles at k_idx=5 -> en=0 and k_idx=5 held during stall; completion delayed by exactly 3 cycles; done still pulses once.
REQ-039 DIM=4: abort at k_idx=2 -> IDLE next cycle, busy=0, no done; a new start is accepted the following cycle.
REQ-040 rst_n driven low between clock edges during CLEAR -> all outputs 0 immediately; start pulsed while busy -> ignored and pass length unchanged.
